sym_bfly_stage_xbar: RTL and testbench

//  Parametrised inter-stage crossbar for the symmetric butterfly network.
//  - Generalises the fixed radix-4 stage-2 to stage-3 transpose to any RADIX and PORTS.
//  - Adds per-port valid/ready flow control, a 1-cycle registered pipeline and a

---
 rtl/sym_bfly_pkg.sv | 38 +++
 rtl/sym_bfly_skid2.sv | 57 +++++
 rtl/sym_bfly_stage_xbar.sv | 111 +++++++++++
 tb/tb_sym_bfly_stage_xbar.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_bfly_pkg.sv
// Shared types and the port permutation used by the symmetric butterfly
// stage crossbars.
package sym_bfly_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } xbar_state_e;

    typedef enum logic {
        MODE_IDENT     = 1'b0,
        MODE_TRANSPOSE = 1'b1
    } xbar_mode_e;

    localparam int SKID_DEPTH = 2;

    // Transpose swaps the two low base-radix digits of the port index inside
    // each radix*radix section. Both mappings are their own inverse.
    function automatic int bfly_perm(input int p, input int radix, input xbar_mode_e mode);
        int sec_size;
        int base;
        int row;
        int col;
        int result;
        sec_size = radix * radix;
        base     = (p / sec_size) * sec_size;
        row      = (p % sec_size) / radix;
        col      = p % radix;
        if (mode == MODE_TRANSPOSE) begin
            result = base + col * radix + row;
        end else begin
            result = p;
        end
        return result;
    endfunction

endpackage

// File: rtl/sym_bfly_skid2.sv
// Two-entry FIFO buffering one crossbar output port. Storage is not reset;
// only the occupancy and pointers are.
module sym_bfly_skid2
    import sym_bfly_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             full
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_ok;
    logic             pop;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop     = valid & pop_ready;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sym_bfly_stage_xbar.sv
// Registered inter-stage crossbar for the symmetric butterfly network with
// per-port flow control and a drain-safe transpose/identity mode switch.
module sym_bfly_stage_xbar
    import sym_bfly_pkg::*;
#(
    parameter int PORTS         = 64,
    parameter int RADIX         = 4,
    parameter int CHANNEL_WIDTH = 18,
    parameter bit RESET_MODE    = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [PORTS-1:0]                     in_valid,
    input  logic [PORTS-1:0][CHANNEL_WIDTH-1:0]  in_data,
    output logic [PORTS-1:0]                     in_ready,
    output logic [PORTS-1:0]                     out_valid,
    output logic [PORTS-1:0][CHANNEL_WIDTH-1:0]  out_data,
    input  logic [PORTS-1:0]                     out_ready,
    input  logic                                 cfg_transpose,
    output logic                                 mode_active,
    output logic                                 busy
);

    if ((RADIX < 2) || (PORTS % (RADIX * RADIX) != 0)) begin : g_bad_params
        $error("sym_bfly_stage_xbar: PORTS must be a multiple of RADIX*RADIX");
    end

    xbar_state_e state;
    xbar_mode_e  mode_q;
    logic        busy_q;

    logic                                mode_bit;
    logic                                mode_match;
    logic                                accept_en;
    logic                                all_empty;
    logic [PORTS-1:0]                    full;
    logic [PORTS-1:0]                    push;
    logic [PORTS-1:0][CHANNEL_WIDTH-1:0] push_data;

    assign mode_bit    = (mode_q == MODE_TRANSPOSE);
    assign mode_match  = (cfg_transpose == mode_bit);
    assign accept_en   = (state == RUN) && mode_match;
    assign all_empty   = ~|out_valid;
    assign mode_active = mode_bit;
    assign busy        = busy_q;

    // Each output port p is fed by input perm(p); since the permutation is an
    // involution, input p's ready also comes from buffer perm(p).
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        localparam int PT = bfly_perm(gi, RADIX, MODE_TRANSPOSE);
        localparam int PI = bfly_perm(gi, RADIX, MODE_IDENT);

        always_comb begin
            in_ready[gi] = accept_en & ~(mode_bit ? full[PT] : full[PI]);
            if (mode_bit) begin
                push[gi]      = in_valid[PT] & in_ready[PT];
                push_data[gi] = in_data[PT];
            end else begin
                push[gi]      = in_valid[PI] & in_ready[PI];
                push_data[gi] = in_data[PI];
            end
        end

        sym_bfly_skid2 #(
            .WIDTH (CHANNEL_WIDTH)
        ) u_skid (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[gi]),
            .push_data (push_data[gi]),
            .pop_ready (out_ready[gi]),
            .valid     (out_valid[gi]),
            .head      (out_data[gi]),
            .full      (full[gi])
        );
    end

    // Mode changes only once every buffer is empty, so no flit is ever routed
    // under a mix of both permutations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            mode_q <= xbar_mode_e'(RESET_MODE);
            busy_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!mode_match) begin
                        state  <= DRAIN;
                        busy_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (all_empty) begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    mode_q <= xbar_mode_e'(cfg_transpose);
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sym_bfly_stage_xbar.sv
// Self-checking bench for sym_bfly_stage_xbar: directed scenarios plus random
// traffic scored against per-output-port queues.
module tb_sym_bfly_stage_xbar;

    localparam int P  = 64;
    localparam int R  = 4;
    localparam int W  = 18;
    localparam int SP = 8;
    localparam int SR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [P-1:0]        in_valid, in_ready, out_valid, out_ready;
    logic [P-1:0][W-1:0] in_data, out_data;
    logic                cfg_transpose, mode_active, busy;

    logic [SP-1:0]        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [SP-1:0][W-1:0] s_in_data, s_out_data;
    logic                 s_cfg_transpose, s_mode_active, s_busy;

    sym_bfly_stage_xbar #(.PORTS(P), .RADIX(R), .CHANNEL_WIDTH(W), .RESET_MODE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cfg_transpose(cfg_transpose), .mode_active(mode_active), .busy(busy)
    );

    sym_bfly_stage_xbar #(.PORTS(SP), .RADIX(SR), .CHANNEL_WIDTH(W), .RESET_MODE(1'b1)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
        .cfg_transpose(s_cfg_transpose), .mode_active(s_mode_active), .busy(s_busy)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int popped = 0;
    bit mm = 1'b1;
    logic [W-1:0] mq [P][$];

    // Output port that input p feeds: transpose swaps the two low base-r digits.
    function automatic int route(input int p, input int r, input bit tr);
        int lo, mid, hi;
        if (!tr) return p;
        lo  = p % r;
        mid = (p / r) % r;
        hi  = p / (r * r);
        return hi * r * r + lo * r + mid;
    endfunction

    // Called just after a negedge with inputs applied; checks outputs against
    // the queues, advances the model and returns at the next negedge.
    task automatic model_cycle();
        logic [P-1:0] er, ev;
        bit dbad;
        int bad_port;
        #1;
        dbad = 1'b0;
        bad_port = 0;
        for (int o = 0; o < P; o++) begin
            ev[o] = (mq[o].size() != 0);
            if (ev[o] && out_data[o] !== mq[o][0] && !dbad) begin
                dbad = 1'b1;
                bad_port = o;
            end
        end
        for (int p = 0; p < P; p++)
            er[p] = (mq[route(p, R, mm)].size() < 2) && (cfg_transpose == mm);
        n_cmp += 3;
        if (in_ready !== er) begin
            n_fail++;
            $display("FAIL in_ready t=%0t got=%h exp=%h", $time, in_ready, er);
        end
        if (out_valid !== ev) begin
            n_fail++;
            $display("FAIL out_valid t=%0t got=%h exp=%h", $time, out_valid, ev);
        end
        if (dbad) begin
            n_fail++;
            $display("FAIL out_data port %0d t=%0t got=%h exp=%h", bad_port, $time,
                     out_data[bad_port], mq[bad_port][0]);
        end
        for (int o = 0; o < P; o++)
            if (ev[o] && out_ready[o]) begin
                void'(mq[o].pop_front());
                popped++;
            end
        for (int p = 0; p < P; p++)
            if (in_valid[p] && er[p]) mq[route(p, R, mm)].push_back(in_data[p]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_model(input int n);
        in_valid  = '0;
        out_ready = '1;
        for (int i = 0; i < n; i++) model_cycle();
    endtask

    task automatic test_reset();
        cfg_transpose = 1'b0;
        in_valid = '0; in_data = '0; out_ready = '1;
        s_in_valid = '0; s_in_data = '0; s_out_ready = '1; s_cfg_transpose = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready_cfg0 got=%h exp=0", in_ready);
        end
        cfg_transpose = 1'b1;
        #1;
        n_cmp += 4;
        if (out_valid !== '0) begin n_fail++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
        if (in_ready !== '1) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=all1", in_ready); end
        if (mode_active !== 1'b1) begin n_fail++; $display("FAIL reset_mode got=%b exp=1", mode_active); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transpose();
        logic [P-1:0] exp_v;
        in_valid = '0;
        in_data[1] = 18'h000A1; in_data[17] = 18'h00111;
        in_valid[1] = 1'b1; in_valid[17] = 1'b1;
        model_cycle();
        in_valid = '0;
        #1;
        exp_v = '0; exp_v[4] = 1'b1; exp_v[20] = 1'b1;
        n_cmp += 3;
        if (out_valid !== exp_v) begin n_fail++; $display("FAIL xpose_valid got=%h exp=%h", out_valid, exp_v); end
        if (out_data[4] !== 18'h000A1) begin n_fail++; $display("FAIL xpose_out4 got=%h exp=000a1", out_data[4]); end
        if (out_data[20] !== 18'h00111) begin n_fail++; $display("FAIL xpose_out20 got=%h exp=00111", out_data[20]); end
        drain_model(2);
    endtask

    task automatic test_backpressure();
        out_ready = '1; out_ready[4] = 1'b0;
        in_valid = '0; in_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data[1] = 18'h00100 + W'(k);
            if (k == 2) begin
                #1;
                n_cmp++;
                if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", in_ready[1]); end
            end
            model_cycle();
        end
        out_ready[4] = 1'b1;
        #1;
        n_cmp += 2;
        if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_pop_same_cycle got=%b exp=0", in_ready[1]); end
        if (out_data[4] !== 18'h00100) begin n_fail++; $display("FAIL bp_first got=%h exp=00100", out_data[4]); end
        model_cycle();
        #1;
        n_cmp += 2;
        if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_next got=%b exp=1", in_ready[1]); end
        if (out_data[4] !== 18'h00101) begin n_fail++; $display("FAIL bp_second got=%h exp=00101", out_data[4]); end
        model_cycle();
        drain_model(3);
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_valid  = {$urandom, $urandom};
            out_ready = {$urandom, $urandom} | {$urandom, $urandom};
            for (int p = 0; p < P; p++) in_data[p] = W'($urandom);
            model_cycle();
        end
        drain_model(3);
    endtask

    task automatic test_full_throughput();
        popped = 0;
        in_valid  = '1;
        out_ready = '1;
        for (int c = 0; c < 100; c++) begin
            for (int p = 0; p < P; p++) in_data[p] = W'((p << 12) | c);
            model_cycle();
        end
        drain_model(2);
        n_cmp++;
        if (popped !== 6400) begin n_fail++; $display("FAIL throughput_count got=%0d exp=6400", popped); end
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            @(posedge clk); @(negedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s timeout busy got=%b exp=0", name, busy); end
    endtask

    task automatic test_mode_switch();
        logic [W-1:0] got [$];
        int guard, quiet_busy;
        bit ready_leak;
        out_ready = '1; out_ready[4] = 1'b0;
        in_valid = '0; in_valid[1] = 1'b1;
        in_data[1] = 18'h00201; model_cycle();
        in_data[1] = 18'h00202; model_cycle();
        in_valid = '0;
        cfg_transpose = 1'b0;
        #1;
        n_cmp += 2;
        if (in_ready !== '0) begin n_fail++; $display("FAIL sw_req_ready got=%h exp=0", in_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_req_busy got=%b exp=0", busy); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk); #1;
            n_cmp += 3;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_drain_busy got=%b exp=1", busy); end
            if (in_ready !== '0) begin n_fail++; $display("FAIL sw_drain_ready got=%h exp=0", in_ready); end
            if (mode_active !== 1'b1) begin n_fail++; $display("FAIL sw_drain_mode got=%b exp=1", mode_active); end
        end
        out_ready[4] = 1'b1;
        guard = 0; quiet_busy = 0; ready_leak = 1'b0;
        while (busy === 1'b1 && guard < 20) begin
            if (out_valid[4]) got.push_back(out_data[4]);
            if (out_valid === '0) quiet_busy++;
            if (in_ready !== '0) ready_leak = 1'b1;
            @(posedge clk); @(negedge clk); #1;
            guard++;
        end
        n_cmp += 6;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_timeout busy got=%b exp=0", busy); end
        if (ready_leak) begin n_fail++; $display("FAIL sw_ready_leak got=1 exp=0"); end
        if (got.size() != 2) begin
            n_fail++; $display("FAIL sw_drain_count got=%0d exp=2", got.size());
        end else if (got[0] !== 18'h00201 || got[1] !== 18'h00202) begin
            n_fail++; $display("FAIL sw_drain_order got=%h,%h exp=00201,00202", got[0], got[1]);
        end
        if (quiet_busy < 1) begin n_fail++; $display("FAIL sw_switch_cycle got=%0d exp>=1", quiet_busy); end
        if (mode_active !== 1'b0) begin n_fail++; $display("FAIL sw_mode got=%b exp=0", mode_active); end
        if (in_ready !== '1) begin n_fail++; $display("FAIL sw_ready_after got=%h exp=all1", in_ready); end
        mq[4].delete();
        mm = 1'b0;
        @(negedge clk);
        in_valid[1] = 1'b1; in_data[1] = 18'h00303;
        model_cycle();
        in_valid = '0;
        #1;
        n_cmp += 2;
        if (out_valid !== P'(2)) begin n_fail++; $display("FAIL ident_valid got=%h exp=%h", out_valid, P'(2)); end
        if (out_data[1] !== 18'h00303) begin n_fail++; $display("FAIL ident_data got=%h exp=00303", out_data[1]); end
        drain_model(2);
    endtask

    task automatic test_back_to_transpose();
        cfg_transpose = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        wait_idle("back_to_xpose");
        n_cmp++;
        if (mode_active !== 1'b1) begin n_fail++; $display("FAIL back_mode got=%b exp=1", mode_active); end
        mm = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_midstream_reset();
        for (int c = 0; c < 10; c++) begin
            in_valid  = {$urandom, $urandom};
            out_ready = (c < 7) ? {$urandom, $urandom} : '0;
            for (int p = 0; p < P; p++) in_data[p] = W'($urandom);
            model_cycle();
        end
        in_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (out_valid !== '0) begin n_fail++; $display("FAIL rst_async_valid got=%h exp=0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        if (mode_active !== 1'b1) begin n_fail++; $display("FAIL rst_async_mode got=%b exp=1", mode_active); end
        for (int o = 0; o < P; o++) mq[o].delete();
        mm = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drain_model(4);
    endtask

    task automatic test_small_instance();
        logic [SP-1:0] exp_v;
        #1;
        n_cmp++;
        if (s_in_ready !== '1) begin n_fail++; $display("FAIL small_ready got=%h exp=ff", s_in_ready); end
        s_in_data[1] = 18'h000A1; s_in_data[2] = 18'h00111;
        s_in_valid = 8'b0000_0110;
        @(posedge clk); @(negedge clk);
        s_in_valid = '0;
        #1;
        exp_v = 8'b0000_0110;
        n_cmp += 3;
        if (s_out_valid !== exp_v) begin n_fail++; $display("FAIL small_valid got=%h exp=%h", s_out_valid, exp_v); end
        if (s_out_data[2] !== 18'h000A1) begin n_fail++; $display("FAIL small_out2 got=%h exp=000a1", s_out_data[2]); end
        if (s_out_data[1] !== 18'h00111) begin n_fail++; $display("FAIL small_out1 got=%h exp=00111", s_out_data[1]); end
        @(posedge clk); @(negedge clk); #1;
        n_cmp++;
        if (s_out_valid !== '0) begin n_fail++; $display("FAIL small_drained got=%h exp=0", s_out_valid); end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_backpressure();
        test_random(300);
        test_full_throughput();
        test_mode_switch();
        test_random(200);
        test_back_to_transpose();
        test_random(200);
        test_midstream_reset();
        test_small_instance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
